// File: rtl/frame_sched.sv
// Frame capture scheduler: picks one sensor frame in every N, gates its capture,
// then hands it to processing with a start/done handshake, counting dropped frames.
module frame_sched #(
    parameter int DIV_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iFVAL,
    input  logic [DIV_W-1:0] iDIV,
    input  logic             iSTART,
    input  logic             iCONT,
    input  logic             iSTOP,
    input  logic             iPROC_DONE,
    output logic             oFrame_En,
    output logic             oProc_Start,
    output logic             oBusy,
    output logic [CNT_W-1:0] oCap_Cnt,
    output logic [CNT_W-1:0] oDrop_Cnt,
    output logic [1:0]       oDbg_State
);

    // Handshake: oProc_Start is a one-cycle pulse when a captured frame ends;
    // iPROC_DONE is a pulse accepted only in PROCESS, including the pulse cycle.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_PROCESS = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] skip_q, skip_d;
    logic [DIV_W-1:0] div_r;
    logic             mode_r;
    logic             fval_q;
    logic             sof, eof;
    logic             latch_cfg, cap_inc, drop_inc;

    assign sof        = iFVAL & ~fval_q;
    assign eof        = ~iFVAL & fval_q;
    assign oDbg_State = state_q;

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        latch_cfg = 1'b0;
        cap_inc   = 1'b0;
        drop_inc  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    state_d   = S_ARMED;
                    skip_d    = '0;
                    latch_cfg = 1'b1;
                end
            end
            S_ARMED: begin
                if (sof) begin
                    if (skip_q == div_r - ONE) begin
                        state_d = S_CAPTURE;
                        skip_d  = '0;
                    end else begin
                        skip_d = skip_q + ONE;
                    end
                end
            end
            S_CAPTURE: begin
                if (eof) begin
                    state_d = S_PROCESS;
                    cap_inc = 1'b1;
                end
            end
            S_PROCESS: begin
                drop_inc = sof;
                if (iPROC_DONE) begin
                    if (mode_r) begin
                        state_d = S_ARMED;
                        skip_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a same-cycle start or frame end.
        if (iSTOP) begin
            state_d   = S_IDLE;
            latch_cfg = 1'b0;
            cap_inc   = 1'b0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            skip_q      <= '0;
            div_r       <= '0;
            mode_r      <= 1'b0;
            fval_q      <= 1'b0;
            oFrame_En   <= 1'b0;
            oProc_Start <= 1'b0;
            oBusy       <= 1'b0;
            oCap_Cnt    <= '0;
            oDrop_Cnt   <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            fval_q      <= iFVAL;
            oFrame_En   <= (state_d == S_CAPTURE);
            oProc_Start <= cap_inc;
            oBusy       <= (state_d != S_IDLE);
            if (latch_cfg) begin
                div_r  <= (iDIV == '0) ? ONE : iDIV;
                mode_r <= iCONT;
            end
            if (cap_inc)
                oCap_Cnt <= oCap_Cnt + CNT_W'(1);
            if (drop_inc && (oDrop_Cnt != {CNT_W{1'b1}}))
                oDrop_Cnt <= oDrop_Cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_frame_sched.sv
// Directed bench for frame_sched: decimation, single-shot, drops, mid-frame arming,
// abort, asynchronous reset and drop-counter saturation.
module tb_frame_sched;

    localparam int DIV_W = 3;
    localparam int CNT_W = 8;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_PROCESS = 2'd3;

    logic             iCLK = 1'b0;
    logic             iRST = 1'b0;
    logic             iFVAL = 1'b0;
    logic [DIV_W-1:0] iDIV = '0;
    logic             iSTART = 1'b0;
    logic             iCONT = 1'b0;
    logic             iSTOP = 1'b0;
    logic             iPROC_DONE = 1'b0;
    logic             oFrame_En;
    logic             oProc_Start;
    logic             oBusy;
    logic [CNT_W-1:0] oCap_Cnt;
    logic [CNT_W-1:0] oDrop_Cnt;
    logic [1:0]       oDbg_State;

    int n_tests = 0;
    int n_fail  = 0;

    frame_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDIV(iDIV), .iSTART(iSTART),
        .iCONT(iCONT), .iSTOP(iSTOP), .iPROC_DONE(iPROC_DONE),
        .oFrame_En(oFrame_En), .oProc_Start(oProc_Start), .oBusy(oBusy),
        .oCap_Cnt(oCap_Cnt), .oDrop_Cnt(oDrop_Cnt), .oDbg_State(oDbg_State)
    );

    always #5 iCLK = ~iCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic do_reset(input string tag);
        iRST = 1'b1; iFVAL = 1'b0; iSTART = 1'b0; iSTOP = 1'b0;
        iPROC_DONE = 1'b0; iDIV = '0; iCONT = 1'b0;
        tick();
        tick();
        check({tag, "_rst_en"},    32'(oFrame_En),   0);
        check({tag, "_rst_busy"},  32'(oBusy),       0);
        check({tag, "_rst_cap"},   32'(oCap_Cnt),    0);
        check({tag, "_rst_drop"},  32'(oDrop_Cnt),   0);
        check({tag, "_rst_state"}, 32'(oDbg_State),  32'(ST_IDLE));
        iRST = 1'b0;
        tick();
    endtask

    task automatic do_start(input string tag, input logic [DIV_W-1:0] div, input logic cont);
        iDIV = div; iCONT = cont; iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        check({tag, "_start_busy"},  32'(oBusy),      1);
        check({tag, "_start_state"}, 32'(oDbg_State), 32'(ST_ARMED));
    endtask

    // One frame: hi cycles valid then lo cycles blank; optionally answers the
    // processing start with a same-cycle done pulse.
    task automatic run_frame(input string tag, input int hi, input int lo,
                             input bit exp_cap, input bit auto_done);
        for (int i = 0; i < hi + lo; i++) begin
            iFVAL = (i < hi);
            tick();
            iPROC_DONE = 1'b0;
            check({tag, "_en"}, 32'(oFrame_En),   32'(exp_cap && (i < hi)));
            check({tag, "_ps"}, 32'(oProc_Start), 32'(exp_cap && (i == hi)));
            if (auto_done && exp_cap && i == hi)
                iPROC_DONE = 1'b1;
        end
    endtask

    task automatic pulse_done();
        iPROC_DONE = 1'b1;
        tick();
        iPROC_DONE = 1'b0;
    endtask

    initial begin
        // Divide by 5, continuous, immediate done.
        do_reset("t1");
        do_start("t1", 3'd5, 1'b1);
        for (int f = 0; f < 15; f++)
            run_frame("t1_frame", 4, 3, (f % 5) == 4, 1'b1);
        check("t1_cap",   32'(oCap_Cnt),   3);
        check("t1_drop",  32'(oDrop_Cnt),  0);
        check("t1_state", 32'(oDbg_State), 32'(ST_ARMED));

        // Ratio 0 acts as 1, single-shot returns to IDLE.
        do_reset("t2");
        do_start("t2", 3'd0, 1'b0);
        run_frame("t2_first", 4, 3, 1'b1, 1'b1);
        check("t2_busy",  32'(oBusy),      0);
        check("t2_state", 32'(oDbg_State), 32'(ST_IDLE));
        for (int f = 0; f < 3; f++)
            run_frame("t2_after", 3, 2, 1'b0, 1'b0);
        check("t2_cap",  32'(oCap_Cnt), 1);
        check("t2_busy2", 32'(oBusy),   0);

        // Done held off for three frames: they are dropped.
        do_reset("t3");
        do_start("t3", 3'd1, 1'b1);
        run_frame("t3_cap1", 3, 2, 1'b1, 1'b0);
        for (int f = 0; f < 3; f++)
            run_frame("t3_drop", 3, 2, 1'b0, 1'b0);
        check("t3_drop",  32'(oDrop_Cnt),  3);
        check("t3_state", 32'(oDbg_State), 32'(ST_PROCESS));
        pulse_done();
        check("t3_rearm", 32'(oDbg_State), 32'(ST_ARMED));
        run_frame("t3_cap2", 3, 2, 1'b1, 1'b1);
        check("t3_cap",   32'(oCap_Cnt),  2);
        check("t3_drop2", 32'(oDrop_Cnt), 3);

        // Arming mid-frame: the partial frame is skipped.
        do_reset("t4");
        iFVAL = 1'b1;
        tick();
        tick();
        do_start("t4", 3'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_partial_en", 32'(oFrame_En), 0);
        end
        iFVAL = 1'b0;
        tick();
        check("t4_partial_ps", 32'(oProc_Start), 0);
        tick();
        run_frame("t4_next", 4, 3, 1'b1, 1'b1);
        check("t4_cap", 32'(oCap_Cnt), 1);

        // One-cycle frame.
        do_reset("t7");
        do_start("t7", 3'd1, 1'b1);
        run_frame("t7_short", 1, 2, 1'b1, 1'b1);
        check("t7_cap", 32'(oCap_Cnt), 1);

        // Abort during capture, then stop beating a same-cycle start.
        do_reset("t5");
        do_start("t5", 3'd1, 1'b1);
        iFVAL = 1'b1;
        tick();
        check("t5_en_on", 32'(oFrame_En), 1);
        tick();
        iSTOP = 1'b1;
        tick();
        iSTOP = 1'b0;
        check("t5_en_off", 32'(oFrame_En),   0);
        check("t5_busy",   32'(oBusy),       0);
        check("t5_state",  32'(oDbg_State),  32'(ST_IDLE));
        iFVAL = 1'b0;
        tick();
        check("t5_ps",  32'(oProc_Start), 0);
        check("t5_cap", 32'(oCap_Cnt),    0);
        iSTART = 1'b1; iSTOP = 1'b1;
        tick();
        iSTART = 1'b0; iSTOP = 1'b0;
        check("t5_stopwins", 32'(oBusy), 0);

        // Asynchronous reset while processing with seven drops.
        do_reset("t6");
        do_start("t6", 3'd1, 1'b1);
        run_frame("t6_cap", 2, 2, 1'b1, 1'b0);
        for (int f = 0; f < 7; f++)
            run_frame("t6_drop", 1, 1, 1'b0, 1'b0);
        check("t6_drop7", 32'(oDrop_Cnt), 7);
        #2 iRST = 1'b1;
        #1;
        check("t6_arst_busy",  32'(oBusy),      0);
        check("t6_arst_cap",   32'(oCap_Cnt),   0);
        check("t6_arst_drop",  32'(oDrop_Cnt),  0);
        check("t6_arst_en",    32'(oFrame_En),  0);
        check("t6_arst_ps",    32'(oProc_Start), 0);
        check("t6_arst_state", 32'(oDbg_State), 32'(ST_IDLE));
        tick();
        iRST = 1'b0;
        tick();
        do_start("t6_again", 3'd2, 1'b1);
        run_frame("t6_skip", 3, 2, 1'b0, 1'b0);
        run_frame("t6_take", 3, 3, 1'b1, 1'b1);
        check("t6_cap_again", 32'(oCap_Cnt), 1);

        // Drop counter saturates at all-ones.
        do_reset("t8");
        do_start("t8", 3'd1, 1'b1);
        run_frame("t8_cap", 2, 2, 1'b1, 1'b0);
        for (int f = 0; f < 260; f++)
            run_frame("t8_drop", 1, 1, 1'b0, 1'b0);
        check("t8_sat", 32'(oDrop_Cnt), 255);
        check("t8_cap", 32'(oCap_Cnt),  1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_sched.md
# frame_sched

Frame capture scheduler for the IPU camera path. Watches the sensor frame-valid strobe and selects one frame out of every N. It gates capture of the selected frame, then hands it to the downstream processing stage with a start/done handshake. Frames that arrive while processing is still running are dropped and counted. Sits between the sensor timing inputs and the frame-buffer/processing datapath; it replaces the fixed divide-by-5 frame enable with an armed, programmable, back-pressured scheduler.

## Interface
- DIV_W, 3, width of decimation ratio input
- CNT_W, 8, width of capture and drop counters
- iCLK  in  1  system clock; all inputs synchronous to it
- iRST  in  1  reset; asynchronous, active-high
- iFVAL  in  1  sensor frame valid (high for the duration of a frame)
- iDIV  in  DIV_W  decimation ratio N; capture 1 of every N frames; 0 treated as 1
- iSTART  in  1  arm pulse; latches iDIV and iCONT
- iCONT  in  1  1 = continuous mode, 0 = single-shot
- iSTOP  in  1  abort/disarm pulse
- iPROC_DONE  in  1  downstream finished processing the last captured frame (pulse)
- oFrame_En  out  1  high while the selected frame is being captured
- oProc_Start  out  1  one-cycle pulse: captured frame complete, begin processing
- oBusy  out  1  high in any state other than IDLE
- oCap_Cnt  out  CNT_W  completed captures; wraps modulo 2^CNT_W
- oDrop_Cnt  out  CNT_W  frame starts seen during PROCESS; saturates at all-ones

## Operation
- Edge detect: fval_q is iFVAL registered. sof = iFVAL & ~fval_q; eof = ~iFVAL & fval_q.
- div_r is latched from iDIV on iSTART (0 becomes 1). mode_r is latched from iCONT. skip_cnt is DIV_W bits.
- IDLE: iSTART -> ARMED, skip_cnt <= 0. Any other input is ignored.
- ARMED: on sof:
  - if skip_cnt == div_r-1: -> CAPTURE, skip_cnt <= 0.
  - else skip_cnt++.
  - Arming mid-frame waits for the next sof; the partial frame is never captured.
- CAPTURE: oFrame_En = 1. On eof: -> PROCESS, oProc_Start pulses, oCap_Cnt++.
- PROCESS: every sof increments oDrop_Cnt (saturating). On iPROC_DONE:
  - mode_r = 1: -> ARMED, skip_cnt <= 0.
  - mode_r = 0: -> IDLE.
  - A sof in the same cycle as iPROC_DONE is counted as dropped and is not captured; the next capture needs a fresh sof in ARMED.
- iSTOP in any state -> IDLE next cycle.
  - Aborted CAPTURE: no oProc_Start, oCap_Cnt unchanged.
  - iSTOP and iSTART in the same cycle: iSTOP wins.
- iSTART outside IDLE is ignored; div_r and mode_r do not change mid-run.
- Reset: state IDLE; fval_q, skip_cnt, div_r, mode_r = 0; oFrame_En, oProc_Start, oBusy = 0; oCap_Cnt = oDrop_Cnt = 0.

## Timing
- All outputs are registered.
- Cycle k = first cycle iFVAL is sampled high. If it is the selected frame, state = CAPTURE and oFrame_En = 1 from k+1.
- Cycle m = first cycle iFVAL is sampled low after capture. At m+1: oFrame_En = 0, oProc_Start = 1 for exactly one cycle, oCap_Cnt incremented.
- iPROC_DONE is honoured from m+1 onward, including the same cycle oProc_Start is high. The state change is visible the following cycle.
- oBusy rises the cycle after iSTART and falls the cycle after the transition to IDLE.
- A frame of iFVAL high for 1 cycle is legal: oFrame_En is high for 1 cycle, and oProc_Start follows on the cycle oFrame_En falls.
- Minimum frame-to-frame spacing: none. Back-to-back frames follow the rules above.

## Test plan
- Reset, iDIV=5, iCONT=1, iSTART, 15 frames with no processing delay (iPROC_DONE one cycle after oProc_Start) -> frames 5, 10, 15 captured; oCap_Cnt=3, oDrop_Cnt=0; oFrame_En is iFVAL delayed by one cycle on those frames only.
- iDIV=0, iCONT=0, iSTART -> first frame captured; after iPROC_DONE the block is IDLE and oBusy=0; subsequent frames are ignored; oCap_Cnt=1.
- iDIV=1, continuous, iPROC_DONE held off for 3 frames after the first capture -> oDrop_Cnt=3; capture resumes on the first sof after done; oCap_Cnt=2 after 5 frames.
- iSTART asserted while iFVAL is already high -> that frame is not counted; capture timing follows from the next sof.
- iSTOP asserted mid-CAPTURE -> oFrame_En low next cycle, no oProc_Start, oCap_Cnt unchanged, oBusy=0.
- iRST asserted asynchronously in PROCESS with oDrop_Cnt=7 -> all outputs 0 immediately; a later iSTART works normally; drop counter saturation verified at 255 with CNT_W=8.
